// File: rtl/serial_summator.sv
// Bit-serial adder/subtractor: LSB-first through one full adder and a carry flop.
// Define SERIAL_SUMMATOR_OVF_EN to build the signed-overflow flag.
module serial_summator #(
  parameter int unsigned WIDTH = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH:0]   summa,
  output logic             ovf
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_DONE
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH:0]   summa_q, summa_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             sub_q, sub_d;
  logic             s_bit;
  logic             cout;

  assign s_bit = a_sh_q[0] ^ b_sh_q[0] ^ carry_q;
  assign cout  = (a_sh_q[0] & b_sh_q[0]) | (a_sh_q[0] & carry_q) | (b_sh_q[0] & carry_q);

  always_comb begin
    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    res_d   = res_q;
    summa_d = summa_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    sub_d   = sub_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_SHIFT;
          a_sh_d  = a;
          b_sh_d  = sub ? ~b : b;
          carry_d = sub;
          sub_d   = sub;
          cnt_d   = '0;
          res_d   = '0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SHIFT: begin
        a_sh_d  = a_sh_q >> 1;
        b_sh_d  = b_sh_q >> 1;
        res_d   = {s_bit, res_q[WIDTH-1:1]};
        carry_d = cout;
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == CNT_LAST) begin
          // Top bit is the carry for add, the borrow (inverted carry) for sub.
          summa_d = {cout ^ sub_q, s_bit, res_q[WIDTH-1:1]};
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      res_q   <= '0;
      summa_q <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      sub_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      res_q   <= res_d;
      summa_q <= summa_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      sub_q   <= sub_d;
    end
  end

`ifdef SERIAL_SUMMATOR_OVF_EN
  logic cin_msb;
  logic ovf_q, ovf_d;

  // On the final shift edge carry_q is exactly the carry into the MSB.
  assign cin_msb = carry_q;

  always_comb begin
    ovf_d = ovf_q;
    if (state_q == S_SHIFT && cnt_q == CNT_LAST) begin
      ovf_d = cout ^ cin_msb;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign ovf = ovf_q;
`else
  assign ovf = 1'b0;
`endif

  assign busy  = (state_q == S_SHIFT);
  assign done  = (state_q == S_DONE);
  assign summa = summa_q;

endmodule

// File: doc/serial_summator.md
# serial_summator

Parametrised bit-serial adder/subtractor: the sequential successor of the combinational `summator`, generalised in operand width and extended with a subtract mode and a start/busy/done handshake. It latches two WIDTH-bit operands, processes one bit per clock LSB-first through a single full adder and a carry flip-flop, and presents a (WIDTH+1)-bit result. It sits beside `summator` as the area-cheap option for wide operands.

## Interface
- `WIDTH`, default 3: operand width in bits, must be ≥ 2.
- `clk`  in  1  system clock, all state changes on the rising edge.
- `rst_n`  in  1  asynchronous reset, active-low.
- `start`  in  1  request a new operation; sampled only in IDLE or DONE.
- `sub`  in  1  mode, sampled with `start`: 0 = a+b, 1 = a−b.
- `a`  in  WIDTH  first operand, sampled with `start`.
- `b`  in  WIDTH  second operand, sampled with `start`.
- `busy`  out  1  high while an operation is in progress.
- `done`  out  1  one-cycle pulse when `summa` is updated.
- `summa`  out  WIDTH+1  result, held until the next result.
- `ovf`  out  1  signed overflow flag (see Configuration).

## Operation
- States: IDLE, SHIFT, DONE.
- IDLE: `busy`=0, `done`=0. If `start`=1, go to SHIFT with these loads:
  - A shift register ← `a`.
  - B shift register ← `b` if `sub`=0, else ~`b`.
  - carry ← `sub`.
  - bit counter ← 0.
  - result shift register ← 0.
- SHIFT: on each edge:
  - s = A[0]^B[0]^carry is shifted into the result MSB; A and B shift right.
  - carry ← majority(A[0], B[0], carry); the previous carry is kept as `cin_msb`.
  - The counter increments.
  - When the counter reaches WIDTH−1 on this edge:
    - `summa` ← {top bit, result}. The top bit is the final carry for add and the inverted final carry (borrow) for sub.
    - Go to DONE.
- Arithmetic:
  - Add: `summa` = a+b, unsigned, exact.
  - Sub: `summa` = a−b modulo 2^(WIDTH+1). `summa[WIDTH]`=1 if and only if a<b unsigned.
- DONE: `done`=1, `busy`=0 for exactly one cycle.
  - `start`=1 in DONE is accepted exactly as in IDLE, going to SHIFT with no idle bubble.
  - Otherwise go to IDLE.
- `start` in SHIFT is ignored. Operand and `sub` changes in SHIFT have no effect.
- `summa`/`ovf` change only on the edge that enters DONE, or on reset.

## Timing
- Reset (`rst_n`=0, immediate, independent of `clk`):
  - state=IDLE.
  - `busy`=0, `done`=0, `summa`=0, `ovf`=0.
  - All internal registers 0.
- Reset during SHIFT aborts the operation. No `done` is produced, and `summa` reads 0.
- Latency:
  - `start` sampled high at edge E0 → `busy`=1 after E0.
  - WIDTH shift edges E1..EWIDTH; `summa` is valid and `done`=1 after EWIDTH; `busy`=0 after EWIDTH.
  - `done` falls after EWIDTH+1.
- Throughput: one result per WIDTH+1 cycles with back-to-back `start`.

## Configuration
- `SERIAL_SUMMATOR_OVF_EN` defined:
  - `ovf` ← carry-out XOR `cin_msb` on the edge entering DONE. This is two's-complement overflow of the WIDTH-bit signed result, valid for both modes.
  - `ovf` is held with `summa`.
- Not defined: `ovf` is tied to 0, and the `cin_msb` register is not built.

## Test plan
- WIDTH=3, reset release, `start`, a=5, b=6, `sub`=0:
  - `busy` for 3 cycles, then `done` pulse with `summa`=4'b1011 (11).
  - `ovf`=1 with the macro (5+6 signed 3-bit overflows), 0 without.
- a=5, b=6, `sub`=1 → `summa`=4'b1111 (borrow set, −1), `ovf`=0.
- Signed overflow, a=3, b=1, add → `summa`=4'b0100, `ovf`=1 with the macro.
- Corner and back-to-back:
  - a=7, b=7 add → 4'b1110.
  - `start` held high in DONE with a=0, b=0 → next `done` exactly 4 cycles later with `summa`=0.
- `start` pulsed again mid-SHIFT with different operands → ignored; first result is unchanged and only one `done` is produced.
- Reset mid-operation:
  - `rst_n` low asynchronously (between edges) during the second SHIFT cycle → `busy`, `done`, `summa` go to 0 immediately.
  - After release, a fresh operation completes normally.
